// File: rtl/seq_detector_prog_if.sv
// Signal bundle for the programmable serial pattern detector: configuration,
// serial data stream, counter control and the detector's result outputs.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               in_valid;
  logic               data_in;
  logic               cnt_clr;
  logic               detected;
  logic [CNT_W-1:0]   match_count;

  // Master drives configuration and data, slave is the detector.
  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output in_valid, data_in, cnt_clr,
    input  cfg_err, detected, match_count
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  in_valid, data_in, cnt_clr,
    output cfg_err, detected, match_count
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector. Keeps a history shift
// register of accepted bits (newest at LSB) and compares its low len bits
// against the loaded pattern. Reports each match as a registered one-cycle
// pulse, counts matches with saturation and flags rejected configurations.
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'h15),
  parameter int                 DEFAULT_LEN = 5,
  parameter bit                 DEFAULT_OVL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_prog_if.slave   bus
);

  localparam int               LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEFAULT_LEN);

  // Architectural state
  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               ovl_q,  ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_q,  det_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic               err_q,  err_d;

  // Datapath helpers
  logic               cfg_ok;
  logic               accept;
  logic               match;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] len_mask;

  // Match evaluation for the bit presented this cycle.
  always_comb begin
    cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
    // A valid cfg_load clears history, so the bit in that cycle is dropped;
    // a rejected load leaves the data path untouched.
    accept = bus.in_valid && !(bus.cfg_load && cfg_ok);
    hist_n = {hist_q[MAX_LEN-2:0], bus.data_in};
    fill_n = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
    // Bits at or above len are don't-care in the comparison.
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    match = accept && (fill_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);
  end

  // Next-state logic for configuration, history, pulses and counter.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    det_d  = match;
    err_d  = bus.cfg_load && !cfg_ok;

    if (bus.cfg_load && cfg_ok) begin
      pat_d  = bus.cfg_pattern;
      len_d  = bus.cfg_len;
      ovl_d  = bus.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = hist_n;
      // Non-overlap mode forgets the matched bits so the next match needs
      // len fresh bits.
      fill_d = (match && !ovl_q) ? '0 : fill_n;
    end

    if (bus.cnt_clr) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register with asynchronous active-high reset to the defaults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= DEFAULT_PAT;
      len_q  <= DEF_LEN_L;
      ovl_q  <= DEFAULT_OVL;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.detected    = det_q;
  assign bus.match_count = cnt_q;
  assign bus.cfg_err     = err_q;

endmodule
